cpu_sequencer: RTL

//  Multi-cycle fetch/decode/execute/writeback controller for the 16-register ALU datapath.

---
 rtl/cpu_sequencer_pkg.sv | 33 +++
 rtl/cpu_sequencer_if.sv | 35 +++
 rtl/cpu_sequencer_decoder.sv | 30 +++
 rtl/cpu_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the fetch/decode/execute/writeback sequencer.
// Holds the FSM state enum, the opcode map and the decoder result struct.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT,
        ST_ERROR
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] EXT_CMP  = 4'hB;

    typedef struct packed {
        logic [3:0] sel_a;
        logic [3:0] sel_b;
        logic       sel_c;
        logic       wb_en;
        logic       is_halt;
    } decode_t;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle between the sequencer, instruction memory and the register/ALU datapath.
// master = sequencer side, slave = memory/datapath side.
interface cpu_sequencer_if #(
    parameter int PC_WIDTH = 16
);
    // Fetch handshake: mem_req rises with mem_addr and both hold stable until the
    // cycle mem_ack is high; mem_rdata is only sampled in that ack cycle.
    logic                start;
    logic                mem_req;
    logic [PC_WIDTH-1:0] mem_addr;
    logic                mem_ack;
    logic [15:0]         mem_rdata;
    logic [15:0]         reg_enable;
    logic [3:0]          mux_sel_a;
    logic [3:0]          mux_sel_b;
    logic                mux_sel_c;
    logic [15:0]         alu_control;
    logic                busy;
    logic                halted;
    logic                error;
    logic [15:0]         instr_count;

    modport master (
        input  start, mem_ack, mem_rdata,
        output mem_req, mem_addr, reg_enable, mux_sel_a, mux_sel_b, mux_sel_c,
               alu_control, busy, halted, error, instr_count
    );

    modport slave (
        output start, mem_ack, mem_rdata,
        input  mem_req, mem_addr, reg_enable, mux_sel_a, mux_sel_b, mux_sel_c,
               alu_control, busy, halted, error, instr_count
    );

endinterface

// File: rtl/cpu_sequencer_decoder.sv
// Combinational instruction decoder: instruction word -> operand selects,
// immediate select, writeback enable and halt flag.
module cpu_sequencer_decoder
    import cpu_sequencer_pkg::*;
(
    input  logic [15:0] i_ir,
    output decode_t     o_dec
);

    logic [3:0] w_op;
    logic [3:0] w_ext;

    assign w_op  = i_ir[15:12];
    assign w_ext = i_ir[7:4];

    always_comb begin
        o_dec         = '0;
        o_dec.sel_a   = i_ir[11:8];
        o_dec.sel_b   = i_ir[3:0];
        o_dec.is_halt = (w_op == OP_HALT);
        if (w_op == OP_RTYPE) begin
            o_dec.wb_en = (w_ext != EXT_CMP);
        end else if (w_op != OP_NOP && w_op != OP_HALT) begin
            // Every remaining opcode is I-type; only CMPI skips writeback.
            o_dec.sel_c = 1'b1;
            o_dec.wb_en = (w_op != OP_CMPI);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller, one instruction in flight.
// Owns the FSM, pc, IR, fetch timeout counter, retired count and registered datapath controls.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus,
    output state_e          o_dbg_state
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_ir;
    logic [15:0]         w_ir_nxt;
    logic [7:0]          r_tmo_cnt;
    logic [15:0]         r_instr_count;
    logic [15:0]         r_reg_en;
    logic [15:0]         r_alu_ctrl;
    logic [3:0]          r_sel_a;
    logic [3:0]          r_sel_b;
    logic                r_sel_c;
    logic                w_fetch_done;
    decode_t             w_dec;

    // Decoding the incoming word lets the selects be registered on the ack edge,
    // so they are already valid in the first DECODE cycle.
    assign w_ir_nxt = w_fetch_done ? bus.mem_rdata : r_ir;

    cpu_sequencer_decoder u_decoder (
        .i_ir  (w_ir_nxt),
        .o_dec (w_dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fetch_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_nxt  = ST_DECODE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_DECODE: begin
                w_state_nxt = w_dec.is_halt ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_state_nxt = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                if (bus.start) w_state_nxt = ST_FETCH;
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_tmo_cnt     <= '0;
            r_instr_count <= '0;
        end else begin
            if (w_fetch_done) begin
                r_ir      <= bus.mem_rdata;
                r_pc      <= r_pc + PC_WIDTH'(1);
                r_tmo_cnt <= '0;
            end else if (r_state == ST_FETCH) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (r_state == ST_WRITEBACK) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_a    <= '0;
            r_sel_b    <= '0;
            r_sel_c    <= 1'b0;
            r_alu_ctrl <= '0;
            r_reg_en   <= '0;
        end else begin
            if (w_fetch_done) begin
                r_sel_a    <= w_dec.sel_a;
                r_sel_b    <= w_dec.sel_b;
                r_sel_c    <= w_dec.sel_c;
                r_alu_ctrl <= bus.mem_rdata;
            end else if (r_state == ST_WRITEBACK ||
                         (r_state == ST_DECODE && w_dec.is_halt)) begin
                r_sel_a    <= '0;
                r_sel_b    <= '0;
                r_sel_c    <= 1'b0;
                r_alu_ctrl <= '0;
            end
            // Loaded only on the EXECUTE->WRITEBACK edge, so it is a single-cycle pulse.
            r_reg_en <= (r_state == ST_EXECUTE && w_dec.wb_en) ? onehot16(w_dec.sel_a) : '0;
        end
    end

    assign bus.mem_req     = (r_state == ST_FETCH);
    assign bus.mem_addr    = r_pc;
    assign bus.reg_enable  = r_reg_en;
    assign bus.mux_sel_a   = r_sel_a;
    assign bus.mux_sel_b   = r_sel_b;
    assign bus.mux_sel_c   = r_sel_c;
    assign bus.alu_control = r_alu_ctrl;
    assign bus.busy        = (r_state == ST_FETCH)   || (r_state == ST_DECODE) ||
                             (r_state == ST_EXECUTE) || (r_state == ST_WRITEBACK);
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.error       = (r_state == ST_ERROR);
    assign bus.instr_count = r_instr_count;
    assign o_dbg_state     = r_state;

endmodule
